// File: rtl/stall_flush_unit.sv
// Pipeline hazard control: load-use stall, branch flush, iterative mul/div hold of E,
// plus saturating counters of stall cycles and flush events.
module stall_flush_unit #(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       RS1_D,
  input  logic [4:0]       RS2_D,
  input  logic [4:0]       RD_E,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             MulDivE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             MdDoneE,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushEvents
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] LAST = 8'(MD_LATENCY - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       md_stall, md_done, lw_stall, br_flush;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_stall  = 1'b0;
    md_done   = 1'b0;
    unique case (state)
      IDLE: begin
        // The IDLE cycle that accepts the op is the first cycle of occupancy.
        if (MulDivE && !PCSrcE) begin
          md_stall  = 1'b1;
          cnt_nxt   = 8'd1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt < LAST) begin
          md_stall = 1'b1;
          cnt_nxt  = cnt + 8'd1;
        end else begin
          md_done   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
    endcase
  end

  assign lw_stall = ResultSrcE0 && (RD_E != 5'd0) && ((RD_E == RS1_D) || (RD_E == RS2_D));
  // A redirect during BUSY is ignored; the held mul/div keeps ownership of E.
  assign br_flush = (state == IDLE) && PCSrcE;

  always_comb begin
    StallF  = 1'b0;
    StallD  = 1'b0;
    StallE  = 1'b0;
    FlushD  = 1'b0;
    FlushE  = 1'b0;
    FlushM  = 1'b0;
    MdDoneE = 1'b0;
    if (!rst) begin
      MdDoneE = md_done;
      if (br_flush) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (md_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (lw_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      StallCycles <= '0;
      FlushEvents <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (StallF && (StallCycles != '1))
        StallCycles <= StallCycles + CNT_W'(1);
      if (FlushD && (FlushEvents != '1))
        FlushEvents <= FlushEvents + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_stall_flush_unit.sv
// Scoreboard bench for stall_flush_unit: directed hazard scenarios then random traffic,
// each cycle's expectation queued by the stimulus and checked by an independent monitor.
module tb_stall_flush_unit;

  localparam int unsigned L = 4;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [4:0]   rs1, rs2, rd;
  logic         ld, pc, md;
  logic         stf, std, ste, fld, fle, flm, done;
  logic [W-1:0] sc, fe;

  stall_flush_unit #(.MD_LATENCY(L), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .RS1_D(rs1), .RS2_D(rs2), .RD_E(rd),
    .ResultSrcE0(ld), .PCSrcE(pc), .MulDivE(md),
    .StallF(stf), .StallD(std), .StallE(ste), .FlushD(fld), .FlushE(fle),
    .FlushM(flm), .MdDoneE(done), .StallCycles(sc), .FlushEvents(fe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [6:0] ctl;  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,MdDoneE}
    int         sc;
    int         fe;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference state: position within the mul/div occupancy window (0 = none in E).
  int   m_pos = 0;
  int   m_sc  = 0;
  int   m_fe  = 0;
  int   sat   = (1 << W) - 1;

  task automatic step(input logic r, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic l, input logic p, input logic m);
    exp_t e;
    int   pos;
    bit   lw, sf, sd, se, fd, fx, fm, dn;
    @(posedge clk);
    #1;
    rst = r; rs1 = a; rs2 = b; rd = d; ld = l; pc = p; md = m;
    cyc++;
    {sf, sd, se, fd, fx, fm, dn} = '0;
    lw  = l && (d != 0) && (d == a || d == b);
    pos = (m_pos != 0) ? m_pos : ((m && !p) ? 1 : 0);
    if (!r) begin
      dn = (m_pos != 0) && (m_pos == L);
      if (m_pos == 0 && p) begin
        fd = 1; fx = 1;
      end else if (pos != 0 && pos < L) begin
        sf = 1; sd = 1; se = 1; fm = 1;
      end else if (lw) begin
        sf = 1; sd = 1; fx = 1;
      end
    end
    e.cyc = cyc;
    e.ctl = {sf, sd, se, fd, fx, fm, dn};
    e.sc  = m_sc;
    e.fe  = m_fe;
    q.push_back(e);
    if (r) begin
      m_pos = 0; m_sc = 0; m_fe = 0;
    end else begin
      if (sf && m_sc < sat) m_sc++;
      if (fd && m_fe < sat) m_fe++;
      m_pos = (pos == 0 || pos == L) ? 0 : pos + 1;
    end
  endtask

  task automatic idle_step(input logic r);
    step(r, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle, away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_checks++;
        if ({stf, std, ste, fld, fle, flm, done} !== e.ctl) begin
          n_fail++;
          $display("FAIL ctl cyc=%0d got=%b exp=%b", e.cyc,
                   {stf, std, ste, fld, fle, flm, done}, e.ctl);
        end
        n_checks++;
        if (sc !== W'(e.sc)) begin
          n_fail++;
          $display("FAIL StallCycles cyc=%0d got=%0d exp=%0d", e.cyc, sc, e.sc);
        end
        n_checks++;
        if (fe !== W'(e.fe)) begin
          n_fail++;
          $display("FAIL FlushEvents cyc=%0d got=%0d exp=%0d", e.cyc, fe, e.fe);
        end
      end
    end
  end

  initial begin
    int unsigned r;
    rst = 1'b1; rs1 = '0; rs2 = '0; rd = '0; ld = 1'b0; pc = 1'b0; md = 1'b0;
    repeat (2) @(posedge clk);

    // Reset with hazard inputs active: all outputs must stay 0.
    step(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1);
    idle_step(1'b0);
    // Load-use on rs2 for one cycle.
    step(1'b0, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    idle_step(1'b0);
    // Load to x0 is never a hazard.
    step(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle_step(1'b0);
    // Mul/div held for its whole occupancy, then one idle cycle.
    repeat (L) step(1'b0, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0, 1'b1);
    idle_step(1'b0);
    // Mul/div to x0 still occupies E.
    repeat (L) step(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    // Branch wins over a same-cycle load-use dependency.
    step(1'b0, 5'd7, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0);
    idle_step(1'b0);
    // Redirect during BUSY is ignored.
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b1);
    repeat (L - 2) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    // Reset in cycle 2 of a mul/div aborts it; the next one runs in full.
    step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    step(1'b1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    idle_step(1'b0);
    repeat (L) step(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b1);
    idle_step(1'b0);
    // Counter saturation after a clean reset.
    idle_step(1'b1);
    repeat (20) step(1'b0, 5'd4, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0);
    repeat (20) step(1'b0, 5'd4, 5'd6, 5'd4, 1'b0, 1'b1, 1'b0);
    repeat (2) idle_step(1'b0);

    // Random traffic on a small register range to make dependencies frequent.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      step(r < 2,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 20));
    end

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=%0d checks exp=completion", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stall_flush_unit.md
# stall_flush_unit

Pipeline control block for the 5-stage RISC-V core, complementing the forwarding path. Forwarding resolves RAW hazards by steering ALU operands. This block covers the hazards forwarding cannot: it stalls F/D and bubbles E on a load-use dependency, flushes D/E on a taken branch/jump, and holds E for an iterative mul/div. It also maintains saturating counters of stall cycles and flush events.

## Interface
Parameters:
- MD_LATENCY, 4, total cycles a mul/div instruction occupies E (legal range 2..255)
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- RS1_D  in  5  rs1 of instruction in D
- RS2_D  in  5  rs2 of instruction in D
- RD_E  in  5  rd of instruction in E
- ResultSrcE0  in  1  instruction in E is a load
- PCSrcE  in  1  taken branch/jump resolved in E
- MulDivE  in  1  instruction in E is mul/div
- StallF  out  1  hold PC
- StallD  out  1  hold IF/ID register
- StallE  out  1  hold ID/EX register
- FlushD  out  1  clear IF/ID register
- FlushE  out  1  clear ID/EX register
- FlushM  out  1  clear EX/MEM register (bubble)
- MdDoneE  out  1  mul/div result valid in E this cycle
- StallCycles  out  CNT_W  cycles with StallF=1, saturating
- FlushEvents  out  CNT_W  cycles with PCSrcE=1 accepted, saturating

## Operation
- Mul/div FSM states: IDLE, BUSY. Internal count `cnt` has width 8.
- IDLE:
  - If MulDivE=1 and PCSrcE=0: mdStall=1 and cnt<=1; next state is BUSY.
  - Otherwise mdStall=0.
- BUSY:
  - mdStall = (cnt < MD_LATENCY-1).
  - While cnt < MD_LATENCY-1, cnt increments.
  - When cnt == MD_LATENCY-1: mdStall=0, MdDoneE=1, next state is IDLE, cnt<=0.
  - MulDivE is ignored in BUSY. The instruction is held, so the input stays high.
- lwStall = ResultSrcE0 & (RD_E != 0) & ((RD_E == RS1_D) | (RD_E == RS2_D)).
- Output priority, highest first:
  1. rst=1: all single-bit outputs 0.
  2. PCSrcE=1 (only honoured in IDLE): FlushD=1, FlushE=1. All stalls 0, FlushM=0.
  3. mdStall=1: StallF=1, StallD=1, StallE=1, FlushM=1. FlushD=0, FlushE=0.
  4. lwStall=1: StallF=1, StallD=1, FlushE=1. StallE=0, FlushM=0.
  5. Otherwise all 0.
- PCSrcE=1 while in BUSY is a protocol violation. It is ignored and the FSM continues.
- The rd==x0 exemption applies only to load-use. Mul/div to x0 still occupies E for MD_LATENCY cycles.
- MdDoneE is 0 in every cycle not named above. This includes IDLE, so MD_LATENCY reaching IDLE on the final cycle is the only assertion.
- Counters:
  - StallCycles increments on every cycle where StallF=1 and rst=0.
  - FlushEvents increments on every cycle where FlushD=1 and rst=0.
  - Both saturate at all-ones and hold there.

## Timing
- Stall and flush outputs are combinational from the inputs and FSM state, valid in the same cycle. No registered latency.
- Mul/div occupancy of E:
  - Exactly MD_LATENCY cycles.
  - StallE is high for the first MD_LATENCY-1 of them.
  - MdDoneE is high on the last, in the same cycle StallE drops.
- Load-use costs exactly one bubble. In the next cycle the load is in M and lwStall deasserts.
- Counters are registered and update at the rising clk edge following the qualifying cycle.
- Reset, checked at the rising edge with rst=1:
  - State returns to IDLE and cnt to 0.
  - StallCycles and FlushEvents go to 0.
- Reset mid-BUSY aborts the sequence. No MdDoneE is produced.
- While rst=1, every single-bit output is 0 regardless of inputs.

## Test plan
- Load-use: ResultSrcE0=1, RD_E=5, RS2_D=5 for one cycle, then ResultSrcE0=0 → StallF=StallD=FlushE=1 for one cycle; StallCycles=1 after the next edge.
- x0 load: ResultSrcE0=1, RD_E=0, RS1_D=0 → all outputs 0; StallCycles unchanged.
- Mul/div, MD_LATENCY=4: MulDivE held high → StallE=1 and FlushM=1 for cycles 1-3, MdDoneE=1 only in cycle 4, IDLE in cycle 5; StallCycles=3.
- Branch with lw dependency same cycle: PCSrcE=1, ResultSrcE0=1, RD_E=RS1_D=7 → FlushD=FlushE=1, StallF=0; FlushEvents=1 after the edge.
- Reset mid-BUSY: assert rst at cycle 2 of a mul/div → all outputs 0, counters 0. The next MulDivE restarts a full 4-cycle sequence.
- Saturation, CNT_W=4: 20 consecutive load-use cycles → StallCycles reaches 15 and holds.
